// File: rtl/codix_risc_ifetch_buffer.sv
// Instruction prefetch buffer: credit-limited in-order memory reads feeding an
// address-tagged FIFO, with redirect flush and drain of stale read data.
//   state | meaning
//   IDLE  | no fetch stream yet; first core request seeds the fetch address
//   FETCH | prefetching, serving hits from the FIFO head, redirecting on miss
//   DRAIN | waiting out stale requests/data after a redirect
module codix_risc_ifetch_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic [AW-1:0] core_a0,
    output logic          core_rdy,
    output logic [DW-1:0] core_q0,
    output logic          mem_req,
    output logic [AW-1:0] mem_a0,
    input  logic          mem_ack,
    input  logic          mem_vld,
    input  logic [DW-1:0] mem_q0
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] STEP = AW'(4);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [CW-1:0] outstanding, out_nxt;
    logic [CW-1:0] discard, discard_nxt;
    logic [AW-1:0] next_pc, next_pc_nxt;
    logic [AW-1:0] push_addr, push_addr_nxt;
    logic [AW-1:0] mem_a0_nxt;
    logic          mem_req_nxt;
    logic          non_empty, accept, vld_fetch, hit, redirect, push, pending;
    logic [AW-1:0] head_addr, exp_addr;
    logic [CW:0]   credit_used;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        non_empty = (count != '0);
        head_addr = fifo_addr[rd_ptr];
        exp_addr  = non_empty ? head_addr : push_addr;
        accept    = mem_req && mem_ack;
        pending   = mem_req && !mem_ack;
        vld_fetch = (state == FETCH) && mem_vld && (outstanding != '0);
        hit       = core_req && (state == FETCH) && non_empty && (head_addr == core_a0);
        redirect  = core_req && (state == FETCH) && (core_a0 != exp_addr);
        push      = vld_fetch && !redirect;
        core_rdy  = hit;
        core_q0   = non_empty ? fifo_data[rd_ptr] : '0;
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        out_nxt       = outstanding;
        discard_nxt   = discard;
        next_pc_nxt   = next_pc;
        push_addr_nxt = push_addr;
        case (state)
            IDLE: begin
                if (core_req) begin
                    next_pc_nxt   = core_a0;
                    push_addr_nxt = core_a0;
                    state_nxt     = FETCH;
                end
            end
            FETCH: begin
                if (accept) begin
                    next_pc_nxt = next_pc + STEP;
                    out_nxt     = out_nxt + CW'(1);
                end
                if (vld_fetch) begin
                    out_nxt       = out_nxt - CW'(1);
                    push_addr_nxt = push_addr + STEP;
                    wr_ptr_nxt    = inc_ptr(wr_ptr);
                end
                if (hit) rd_ptr_nxt = inc_ptr(rd_ptr);
                count_nxt = count + CW'(vld_fetch) - CW'(hit);
                // Everything in flight at the redirect becomes stale and is counted off in DRAIN.
                if (redirect) begin
                    count_nxt     = '0;
                    wr_ptr_nxt    = '0;
                    rd_ptr_nxt    = '0;
                    next_pc_nxt   = core_a0;
                    push_addr_nxt = core_a0;
                    discard_nxt   = out_nxt;
                    out_nxt       = '0;
                    state_nxt     = ((discard_nxt != '0) || pending) ? DRAIN : FETCH;
                end
            end
            DRAIN: begin
                if (accept) discard_nxt = discard_nxt + CW'(1);
                if (mem_vld && (discard != '0)) discard_nxt = discard_nxt - CW'(1);
                if (core_req) begin
                    next_pc_nxt   = core_a0;
                    push_addr_nxt = core_a0;
                end
                if ((discard_nxt == '0) && !pending) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A raised request is held until accepted; new ones are issued against next-cycle credit.
    always_comb begin
        mem_req_nxt = mem_req;
        mem_a0_nxt  = mem_a0;
        credit_used = {1'b0, count_nxt} + {1'b0, out_nxt};
        if (!mem_req || accept) begin
            mem_req_nxt = 1'b0;
            if ((state_nxt == FETCH) && (credit_used < DEPTH_C)) begin
                mem_req_nxt = 1'b1;
                mem_a0_nxt  = next_pc_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            next_pc     <= '0;
            push_addr   <= '0;
            mem_req     <= 1'b0;
            mem_a0      <= '0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            outstanding <= out_nxt;
            discard     <= discard_nxt;
            next_pc     <= next_pc_nxt;
            push_addr   <= push_addr_nxt;
            mem_req     <= mem_req_nxt;
            mem_a0      <= mem_a0_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_data[wr_ptr] <= mem_q0;
        end
    end

endmodule

// File: tb/tb_codix_risc_ifetch_buffer.sv
// Directed bench for the fetch buffer: stream, backpressure, branch redirects,
// address wrap and asynchronous reset, against a 1-cycle-ACK / 2-cycle-VLD memory.
module tb_codix_risc_ifetch_buffer;

    logic        clk;
    logic        rst_n;
    logic        core_req;
    logic [31:0] core_a0;
    logic        core_rdy;
    logic [31:0] core_q0;
    logic        mem_req;
    logic [31:0] mem_a0;
    logic        mem_ack;
    logic        mem_vld;
    logic [31:0] mem_q0;
    logic        inj_vld;
    logic        d1v, d2v;
    logic [31:0] d1a, d2a;
    int          n_checks;
    int          n_fail;

    codix_risc_ifetch_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .core_req (core_req),
        .core_a0  (core_a0),
        .core_rdy (core_rdy),
        .core_q0  (core_q0),
        .mem_req  (mem_req),
        .mem_a0   (mem_a0),
        .mem_ack  (mem_ack),
        .mem_vld  (mem_vld),
        .mem_q0   (mem_q0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] dfun(input logic [31:0] a);
        return a ^ 32'h3C5A_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // Memory: data for a request accepted in cycle k is returned in cycle k+2.
    initial begin
        mem_vld = 1'b0;
        mem_q0  = '0;
        d1v = 1'b0; d2v = 1'b0; d1a = '0; d2a = '0;
        forever begin
            @(posedge clk);
            #3;
            if (!rst_n) begin
                d1v = 1'b0; d2v = 1'b0; mem_vld = 1'b0;
            end else begin
                mem_vld = d2v | inj_vld;
                mem_q0  = inj_vld ? 32'hBAD0_BAD0 : dfun(d2a);
                d2v = d1v; d2a = d1a;
                d1v = mem_req & mem_ack; d1a = mem_a0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic req, input logic [31:0] a);
        @(posedge clk);
        #1;
        core_req = req;
        core_a0  = a;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0; core_req = 1'b0; mem_ack = 1'b1; inj_vld = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; core_req = 1'b1; core_a0 = 32'h100; mem_ack = 1'b1; inj_vld = 1'b0;
        #3;
        chk("rst_core_rdy", core_rdy, 32'd0);
        chk("rst_mem_req", mem_req, 32'd0);
        chk("rst_mem_a0", mem_a0, 32'd0);
        chk("rst_core_q0", core_q0, 32'd0);
        @(posedge clk);
        #2;
        chk("rst_hold_mem_req", mem_req, 32'd0);
        chk("rst_hold_core_rdy", core_rdy, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; core_req = 1'b0;

        // Stream from 0x100
        cyc(1'b1, 32'h100); chk("s_idle_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h100); chk("s_c1_mem_req", mem_req, 32'd1);
        chk("s_c1_mem_a0", mem_a0, 32'h100); chk("s_c1_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h100); chk("s_c2_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h100); chk("s_c3_rdy", core_rdy, 32'd0);
        for (int i = 0; i < 8; i++) begin
            a = 32'h100 + 32'(4 * i);
            cyc(1'b1, a);
            chk($sformatf("s_hit%0d_rdy", i), core_rdy, 32'd1);
            chk($sformatf("s_hit%0d_q0", i), core_q0, dfun(a));
        end

        // Backpressure: core stalls, FIFO fills to 4, stray mem_vld ignored
        cyc(1'b0, 32'h120);
        for (int k = 13; k < 18; k++) begin
            cyc(1'b0, 32'h120);
            inj_vld = (k == 16);
            chk($sformatf("bp_c%0d_mem_req", k), mem_req, 32'd0);
        end
        cyc(1'b1, 32'h120);
        chk("bp_prepop_mem_req", mem_req, 32'd0);
        chk("bp_pop0_rdy", core_rdy, 32'd1); chk("bp_pop0_q0", core_q0, dfun(32'h120));
        cyc(1'b1, 32'h124);
        chk("bp_resume_mem_req", mem_req, 32'd1); chk("bp_resume_mem_a0", mem_a0, 32'h130);
        chk("bp_pop1_rdy", core_rdy, 32'd1); chk("bp_pop1_q0", core_q0, dfun(32'h124));
        for (int i = 2; i < 8; i++) begin
            a = 32'h120 + 32'(4 * i);
            cyc(1'b1, a);
            chk($sformatf("bp_pop%0d_rdy", i), core_rdy, 32'd1);
            chk($sformatf("bp_pop%0d_q0", i), core_q0, dfun(a));
        end

        // Branch 0x108 -> 0x400 with two reads outstanding
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100);
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + 32'(4 * i);
            cyc(1'b1, a);
            chk($sformatf("br_hit%0d_q0", i), core_q0, dfun(a));
        end
        cyc(1'b1, 32'h400);
        chk("br_c7_rdy", core_rdy, 32'd0); chk("br_c7_mem_a0", mem_a0, 32'h118);
        cyc(1'b1, 32'h400);
        chk("br_c8_mem_req", mem_req, 32'd0); chk("br_c8_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h400);
        chk("br_c9_mem_req", mem_req, 32'd0); chk("br_c9_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h400);
        chk("br_c10_mem_req", mem_req, 32'd1); chk("br_c10_mem_a0", mem_a0, 32'h400);
        cyc(1'b1, 32'h400); chk("br_c11_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h400); chk("br_c12_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h400);
        chk("br_c13_rdy", core_rdy, 32'd1); chk("br_c13_q0", core_q0, dfun(32'h400));
        cyc(1'b1, 32'h404);
        chk("br_c14_rdy", core_rdy, 32'd1); chk("br_c14_q0", core_q0, dfun(32'h404));

        // Redirect while the request at 0x10C is still unaccepted
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100);
        cyc(1'b1, 32'h100);
        mem_ack = 1'b0;
        chk("pd_c4_rdy", core_rdy, 32'd1); chk("pd_c4_mem_a0", mem_a0, 32'h10C);
        cyc(1'b1, 32'h104);
        chk("pd_c5_q0", core_q0, dfun(32'h104)); chk("pd_c5_mem_a0", mem_a0, 32'h10C);
        cyc(1'b1, 32'h400);
        chk("pd_c6_rdy", core_rdy, 32'd0); chk("pd_c6_mem_req", mem_req, 32'd1);
        chk("pd_c6_mem_a0", mem_a0, 32'h10C);
        cyc(1'b1, 32'h400);
        chk("pd_c7_mem_req", mem_req, 32'd1); chk("pd_c7_mem_a0", mem_a0, 32'h10C);
        mem_ack = 1'b1;
        cyc(1'b1, 32'h400);
        chk("pd_c8_mem_req", mem_req, 32'd0); chk("pd_c8_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h400); chk("pd_c9_mem_req", mem_req, 32'd0);
        cyc(1'b1, 32'h400);
        chk("pd_c10_mem_req", mem_req, 32'd1); chk("pd_c10_mem_a0", mem_a0, 32'h400);
        cyc(1'b1, 32'h400); chk("pd_c11_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h400); chk("pd_c12_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h400);
        chk("pd_c13_rdy", core_rdy, 32'd1); chk("pd_c13_q0", core_q0, dfun(32'h400));

        // Address wrap and FIFO pointer wrap
        do_reset();
        cyc(1'b1, 32'hFFFF_FFF8);
        cyc(1'b1, 32'hFFFF_FFF8); chk("wr_c1_mem_a0", mem_a0, 32'hFFFF_FFF8);
        cyc(1'b1, 32'hFFFF_FFF8); chk("wr_c2_mem_a0", mem_a0, 32'hFFFF_FFFC);
        cyc(1'b1, 32'hFFFF_FFF8); chk("wr_c3_mem_a0", mem_a0, 32'h0000_0000);
        for (int i = 0; i < 9; i++) begin
            a = 32'hFFFF_FFF8 + 32'(4 * i);
            cyc(1'b1, a);
            chk($sformatf("wr_hit%0d_rdy", i), core_rdy, 32'd1);
            chk($sformatf("wr_hit%0d_q0", i), core_q0, dfun(a));
        end

        // Asynchronous reset with reads in flight, then a clean restart at 0x0
        rst_n = 1'b0;
        #1;
        chk("ar_core_rdy", core_rdy, 32'd0);
        chk("ar_mem_req", mem_req, 32'd0);
        chk("ar_mem_a0", mem_a0, 32'd0);
        chk("ar_core_q0", core_q0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; core_req = 1'b0;
        #1;
        chk("ar_idle_mem_req", mem_req, 32'd0);
        cyc(1'b1, 32'h0); chk("ar_c0_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h0);
        chk("ar_c1_mem_req", mem_req, 32'd1); chk("ar_c1_mem_a0", mem_a0, 32'h0);
        cyc(1'b1, 32'h0); chk("ar_c2_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h0); chk("ar_c3_rdy", core_rdy, 32'd0);
        cyc(1'b1, 32'h0);
        chk("ar_c4_rdy", core_rdy, 32'd1); chk("ar_c4_q0", core_q0, dfun(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/codix_risc_ifetch_buffer.md
CODIX_RISC_IFETCH_BUFFER -- requirements
Module: codix_risc_ifetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: prefetch FIFO entries; also the credit limit.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: instruction width.
REQ-004 CLK  in  1  single clock; all state changes on rising edge.
REQ-005 RST  in  1  asynchronous, active-low reset.
REQ-006 core_REQ  in  1  core requests the instruction at core_A0 this cycle.
REQ-007 core_A0  in  AW  core fetch address, word aligned.
REQ-008 core_RDY  out  1  core_Q0 is valid for core_A0; the head entry is consumed this cycle.
REQ-009 core_Q0  out  DW  instruction word from the FIFO head.
REQ-010 mem_REQ  out  1  read request to the memory read_only port.
REQ-011 mem_A0  out  AW  read address.
REQ-012 mem_ACK  in  1  memory accepts the request when mem_REQ=1 and mem_ACK=1.
REQ-013 mem_VLD  in  1  read data returned, in request order.
REQ-014 mem_Q0  in  DW  read data, qualified by mem_VLD.

Function
REQ-015 SHALL implement a DEPTH-entry circular FIFO of {addr, data}, with a pointer wrap at DEPTH.
REQ-016 SHALL keep next_pc (the next address to request), push_addr (the address of the next mem_VLD), outstanding (0..DEPTH) and discard (0..DEPTH) counters.
REQ-017 SHALL use the FSM states IDLE, FETCH and DRAIN; the reset state is IDLE.
REQ-018 IDLE: on core_REQ, next_pc and push_addr SHALL load core_A0, and the FSM SHALL go to FETCH; core_RDY=0.
REQ-019 FETCH: mem_REQ SHALL assert, with mem_A0=next_pc, only when occupancy+outstanding < DEPTH.
REQ-020 Once asserted, mem_REQ and mem_A0 SHALL hold stable until mem_ACK, in any state.
REQ-021 On accept, next_pc SHALL increment by 4 and outstanding SHALL increment.
REQ-022 On mem_VLD in FETCH, the block SHALL push {push_addr, mem_Q0}, then push_addr+=4 and outstanding-=1.
REQ-023 Hit: core_RDY = core_REQ AND FETCH AND FIFO non-empty AND head.addr==core_A0; a hit SHALL pop the head.
REQ-024 Expected address = head.addr if non-empty, else push_addr.
REQ-025 When core_REQ=1 and core_A0 equals the expected address but the FIFO is empty, the block SHALL wait with no redirect.
REQ-026 Redirect: core_REQ AND FETCH AND core_A0 != expected address. On redirect:
- flush the FIFO;
- load next_pc and push_addr with core_A0;
- discard = outstanding after this cycle's updates;
- go to DRAIN if discard>0 or an unaccepted mem_REQ is pending, else stay in FETCH.
REQ-027 DRAIN: no new requests SHALL issue. A pending request accepted in DRAIN SHALL increment discard. Each mem_VLD SHALL be dropped and decrement discard. The FSM SHALL return to FETCH when discard reaches 0 and no request is pending.
REQ-028 core_REQ in DRAIN SHALL reload next_pc and push_addr only, and core_RDY=0.
REQ-029 Push and pop SHALL work in the same cycle, including when the FIFO is full; the credit rule guarantees no overflow.
REQ-030 mem_VLD with outstanding=0 and discard=0 is a protocol error and SHALL be ignored.
REQ-031 Latency: a miss at cycle N SHALL give mem_REQ at N+1; mem_VLD at cycle M SHALL give core_RDY from M+1 (no bypass).
REQ-032 All address arithmetic SHALL be modulo 2^AW.

Reset
REQ-033 While RST=0, all of the following SHALL hold immediately, regardless of clock:
- core_RDY=0, mem_REQ=0;
- mem_A0=0, core_Q0=0;
- FIFO empty, all counters 0, state IDLE.
REQ-034 Reset mid-transaction SHALL abandon all outstanding requests; the memory is reset together with this block.

Verification
REQ-035 Stream: core_REQ at 0x100,0x104,...; memory with a 1-cycle ACK and 2-cycle VLD -> first core_RDY 4 cycles after the first core_REQ, then core_RDY every cycle with matching data.
REQ-036 Backpressure: the core stalls with the FIFO holding 4 entries -> no more than 4 accepted requests beyond the consumed ones; mem_REQ=0 until a pop.
REQ-037 Branch: core_A0 goes 0x108 -> 0x400 with 2 outstanding -> DRAIN; 2 mem_VLD dropped; mem_A0=0x400 after the drain; first core_RDY carries the data for 0x400.
REQ-038 Redirect during an unaccepted mem_REQ at 0x10C -> mem_A0 held at 0x10C until ACK, its data dropped, then request 0x400.
REQ-039 Wrap: next_pc=0xFFFFFFFC -> next request at 0x00000000; FIFO pointers wrap after 4 pushes with correct order.
REQ-040 Async reset asserted between ACK and VLD -> outputs 0 within the same cycle; after release, a core_REQ at 0x0 restarts cleanly.
